// File: rtl/thunderbird_seq.sv
// thunderbird_seq: turn / hazard lamp sequencer with brake overlay.
// Drives LAMPS lamps per side. Each step is held for DIV clocks. After each
// sequence the lamps stay off for HOLD_OFF*DIV clocks before going back to IDLE.
//
// state   | meaning
// IDLE    | no sequence running; a request is sampled on every clock
// LEFT    | left side steps through top-k patterns, k = 1..LAMPS
// RIGHT   | right side steps through top-k patterns, k = 1..LAMPS
// HAZ     | both sides fully lit for one step
// GAP     | all-off gap after a sequence; requests are ignored here
module thunderbird_seq #(
  parameter int LAMPS    = 3,
  parameter int DIV      = 4,
  parameter int HOLD_OFF = 1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] L,
  output logic [LAMPS-1:0] R,
  output logic             busy
);

  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STEP_W = $clog2(LAMPS + 1);
  localparam int GAP_N  = HOLD_OFF * DIV;
  localparam int GAP_W  = (GAP_N > 1) ? $clog2(GAP_N) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LAMPS);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_N > 0) ? GAP_N - 1 : 0);
  localparam logic [LAMPS-1:0]  ONES      = {LAMPS{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEFT  = 3'd1,
    S_RIGHT = 3'd2,
    S_HAZ   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // With no hold-off the sequence ends straight back in IDLE.
  localparam state_t S_DONE = (HOLD_OFF > 0) ? S_GAP : S_IDLE;

  state_t            r_state, w_state_nxt;
  logic [TICK_W-1:0] r_tick, w_tick_nxt;
  logic [STEP_W-1:0] r_step, w_step_nxt;
  logic [GAP_W-1:0]  r_gap, w_gap_nxt;
  logic [LAMPS-1:0]  r_l, r_r, w_l_nxt, w_r_nxt;
  logic              r_busy, w_busy_nxt;
  logic              w_tick_end;
  logic              w_illegal;

  // Step k lights the top k lamps; the MSB is the first lamp lit.
  function automatic logic [LAMPS-1:0] f_mask(input logic [STEP_W-1:0] k);
    logic [LAMPS-1:0] m;
    m = '0;
    for (int i = 0; i < LAMPS; i++) begin
      m[i] = (i >= LAMPS - int'(k));
    end
    return m;
  endfunction

  // State, counters and lamp outputs; every output is registered.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_step  <= '0;
      r_gap   <= '0;
      r_l     <= '0;
      r_r     <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_step  <= w_step_nxt;
      r_gap   <= w_gap_nxt;
      r_l     <= w_l_nxt;
      r_r     <= w_r_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Next state and counters; hazard preempts a turn sequence ahead of its step end.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_step_nxt  = r_step;
    w_gap_nxt   = r_gap;
    w_illegal   = 1'b0;
    w_tick_end  = (r_tick == TICK_LAST);
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        w_step_nxt = '0;
        w_gap_nxt  = '0;
        if (hazard || (left && right)) begin
          w_state_nxt = S_HAZ;
        end else if (right) begin
          w_state_nxt = S_RIGHT;
          w_step_nxt  = STEP_W'(1);
        end else if (left) begin
          w_state_nxt = S_LEFT;
          w_step_nxt  = STEP_W'(1);
        end
      end
      S_LEFT, S_RIGHT: begin
        if (hazard) begin
          w_state_nxt = S_HAZ;
          w_tick_nxt  = '0;
          w_step_nxt  = '0;
        end else if (w_tick_end) begin
          w_tick_nxt = '0;
          if (r_step == STEP_LAST) begin
            w_state_nxt = S_DONE;
            w_step_nxt  = '0;
            w_gap_nxt   = '0;
          end else begin
            w_step_nxt = r_step + STEP_W'(1);
          end
        end else begin
          w_tick_nxt = r_tick + TICK_W'(1);
        end
      end
      S_HAZ: begin
        if (w_tick_end) begin
          w_tick_nxt  = '0;
          w_gap_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_tick_nxt = r_tick + TICK_W'(1);
        end
      end
      S_GAP: begin
        if (r_gap == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_gap_nxt   = '0;
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tick_nxt  = '0;
        w_step_nxt  = '0;
        w_gap_nxt   = '0;
        w_illegal   = 1'b1;
      end
    endcase
  end

  // Lamp pattern for the state being entered, with the brake overlay applied.
  always_comb begin
    w_l_nxt    = '0;
    w_r_nxt    = '0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_LEFT: begin
        w_l_nxt = f_mask(w_step_nxt);
        w_r_nxt = brake ? ONES : '0;
      end
      S_RIGHT: begin
        w_l_nxt = brake ? ONES : '0;
        w_r_nxt = f_mask(w_step_nxt);
      end
      S_HAZ: begin
        w_l_nxt = ONES;
        w_r_nxt = ONES;
      end
      default: begin
        w_l_nxt = brake ? ONES : '0;
        w_r_nxt = brake ? ONES : '0;
      end
    endcase
    if (w_illegal) begin
      w_l_nxt = '0;
      w_r_nxt = '0;
    end
  end

  assign L    = r_l;
  assign R    = r_r;
  assign busy = r_busy;

endmodule

// File: tb/tb_thunderbird_seq.sv
// Scoreboard bench for thunderbird_seq: the expected lamp pattern is queued
// when each input set is driven and checked just after the following edge.
module tb_thunderbird_seq;

  logic       Clk = 1'b0;
  logic       reset;
  logic       left, right, hazard, brake;
  logic [2:0] L, R;
  logic       busy;
  logic       left5, right5, hazard5, brake5;
  logic [4:0] L5, R5;
  logic       busy5;

  thunderbird_seq #(.LAMPS(3), .DIV(2), .HOLD_OFF(1)) dut (
    .Clk(Clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
    .brake(brake), .L(L), .R(R), .busy(busy)
  );

  thunderbird_seq #(.LAMPS(5), .DIV(1), .HOLD_OFF(1)) dut5 (
    .Clk(Clk), .reset(reset), .left(left5), .right(right5), .hazard(hazard5),
    .brake(brake5), .L(L5), .R(R5), .busy(busy5)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          dut;
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int d);
    if (d == 0) return {25'b0, L, R, busy};
    return {21'b0, L5, R5, busy5};
  endfunction

  // One clock: wait for the edge, settle, then compare against the queue head.
  task automatic cyc();
    exp_t e;
    @(posedge Clk);
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_vec(e.tag, obs(e.dut), e.v);
    end
  endtask

  task automatic step3(input logic l, input logic r, input logic h, input logic b,
                       input logic [2:0] el, input logic [2:0] er, input logic eb,
                       input string tag);
    left = l; right = r; hazard = h; brake = b;
    sb.push_back('{0, tag, {25'b0, el, er, eb}});
    cyc();
  endtask

  task automatic step5(input logic l, input logic [4:0] el, input logic eb, input string tag);
    left5 = l;
    sb.push_back('{1, tag, {21'b0, el, 5'b00000, eb}});
    cyc();
  endtask

  logic [2:0] seq_lamp [9];
  logic       seq_busy [9];

  initial begin
    seq_lamp = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
    seq_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    reset = 1'b0;
    left = 0; right = 0; hazard = 0; brake = 0;
    left5 = 0; right5 = 0; hazard5 = 0; brake5 = 0;
    #1;
    check_vec("reset_state", obs(0), 32'd0);
    check_vec("reset_state5", obs(1), 32'd0);
    #11 reset = 1'b1;

    // Single-cycle left pulse.
    step3(1, 0, 0, 0, 3'b100, 3'b000, 1, "left_s1a");
    for (int i = 1; i < 9; i++)
      step3(0, 0, 0, 0, seq_lamp[i], 3'b000, seq_busy[i], $sformatf("left_seq%0d", i));

    // Both turn requests together act as hazard.
    step3(1, 1, 0, 0, 3'b111, 3'b111, 1, "lr_haz0");
    step3(0, 0, 0, 0, 3'b111, 3'b111, 1, "lr_haz1");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 1, "lr_gap0");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 1, "lr_gap1");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 0, "lr_idle");

    // Right held: period of nine clocks including the IDLE clock.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 9; i++)
        step3(0, 1, 0, 0, 3'b000, seq_lamp[i], seq_busy[i], $sformatf("right_hold_p%0d_%0d", p, i));
    right = 0;

    // Hazard preempts a running left sequence; left does not resume.
    step3(1, 0, 0, 0, 3'b100, 3'b000, 1, "pre_l0");
    step3(0, 0, 0, 0, 3'b100, 3'b000, 1, "pre_l1");
    step3(0, 0, 0, 0, 3'b110, 3'b000, 1, "pre_l2");
    step3(0, 0, 1, 0, 3'b111, 3'b111, 1, "pre_haz0");
    step3(0, 0, 1, 0, 3'b111, 3'b111, 1, "pre_haz1");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 1, "pre_gap0");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 1, "pre_gap1");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 0, "pre_idle");

    // Right request during a left sequence is ignored.
    step3(1, 0, 0, 0, 3'b100, 3'b000, 1, "ign_r0");
    step3(0, 1, 0, 0, 3'b100, 3'b000, 1, "ign_r1");
    step3(0, 1, 0, 0, 3'b110, 3'b000, 1, "ign_r2");
    for (int i = 3; i < 9; i++)
      step3(0, 0, 0, 0, seq_lamp[i], 3'b000, seq_busy[i], $sformatf("ign_r_seq%0d", i));

    // Brake overlay during a right sequence, then GAP and IDLE.
    step3(0, 1, 0, 1, 3'b111, 3'b100, 1, "brk_r0");
    for (int i = 1; i < 6; i++)
      step3(0, 0, 0, 1, 3'b111, seq_lamp[i], 1, $sformatf("brk_r%0d", i));
    step3(0, 0, 0, 1, 3'b111, 3'b111, 1, "brk_gap0");
    step3(0, 0, 0, 1, 3'b111, 3'b111, 1, "brk_gap1");
    step3(0, 0, 0, 1, 3'b111, 3'b111, 0, "brk_idle");
    step3(0, 0, 1, 1, 3'b111, 3'b111, 1, "brk_haz0");
    step3(0, 0, 0, 1, 3'b111, 3'b111, 1, "brk_haz1");
    step3(0, 0, 0, 1, 3'b111, 3'b111, 1, "brk_hgap0");
    step3(0, 0, 0, 1, 3'b111, 3'b111, 1, "brk_hgap1");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 0, "brk_off");

    // Asynchronous reset in mid-sequence, checked between edges.
    step3(1, 0, 0, 0, 3'b100, 3'b000, 1, "ar_l0");
    step3(0, 0, 0, 0, 3'b100, 3'b000, 1, "ar_l1");
    step3(0, 0, 0, 0, 3'b110, 3'b000, 1, "ar_l2");
    #1 reset = 1'b0;
    #1 check_vec("async_reset", obs(0), 32'd0);
    #1 reset = 1'b1;
    step3(0, 0, 0, 0, 3'b000, 3'b000, 0, "ar_idle");

    // Right pulse during GAP is not latched.
    step3(1, 0, 0, 0, 3'b100, 3'b000, 1, "gap_ign0");
    for (int i = 1; i < 7; i++)
      step3(0, 0, 0, 0, seq_lamp[i], 3'b000, 1, $sformatf("gap_ign%0d", i));
    step3(0, 1, 0, 0, 3'b000, 3'b000, 1, "gap_ign_r");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 0, "gap_ign_idle");
    step3(0, 0, 0, 0, 3'b000, 3'b000, 0, "gap_ign_stay");

    // Five lamps, one clock per step.
    step5(1, 5'b10000, 1, "l5_1");
    step5(0, 5'b11000, 1, "l5_2");
    step5(0, 5'b11100, 1, "l5_3");
    step5(0, 5'b11110, 1, "l5_4");
    step5(0, 5'b11111, 1, "l5_5");
    step5(0, 5'b00000, 1, "l5_gap");
    step5(0, 5'b00000, 0, "l5_idle");

    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/thunderbird_seq.md
Name: thunderbird_seq

Overview:
Parametrised successor to the fixed 3-lamp turn/hazard light sequencer. Drives LAMPS lamps per side with a programmable step rate (DIV clocks per step) and a programmable all-off gap between sequences. Adds a dedicated hazard input with preemption, a brake overlay, and a busy flag. Sits between the driver-switch inputs and the lamp drivers.

Parameters:
LAMPS, 3, lamps per side; legal range >=2.
DIV, 4, clock cycles each step is held; legal range >=1.
HOLD_OFF, 1, number of DIV-cycle all-off gap steps after each sequence; 0 means return directly to IDLE.

Ports:
Clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
left  in  1  left turn request, level-sampled on Clk
right  in  1  right turn request, level-sampled on Clk
hazard  in  1  hazard request, level-sampled on Clk
brake  in  1  brake overlay, level-sampled on Clk
L  out  LAMPS  left lamps; L[LAMPS-1] is the first lamp lit
R  out  LAMPS  right lamps; R[LAMPS-1] is the first lamp lit
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (reset=0): state=IDLE; step, tick and gap counters=0; L=R=0; busy=0. Takes effect immediately, no clock needed, including mid-sequence. The first request is sampled at the first rising edge after reset goes high.
- State machine states: IDLE, LEFT, RIGHT, HAZ, GAP.
- All outputs are registered. L, R and busy update on the same edge as the state change; there is no combinational path from inputs to outputs.
- IDLE request priority, evaluated every clock:
  - hazard=1, or left and right both 1 -> HAZ.
  - otherwise right=1 -> RIGHT at step 1.
  - otherwise left=1 -> LEFT at step 1.
  - otherwise stay in IDLE.
  - Entering any active state clears tick to 0.
- tick counts 0..DIV-1 while in any active state. A "step end" is the clock where tick==DIV-1; tick wraps to 0 on that clock.
- LEFT/RIGHT: step k (1..LAMPS) lights the top k bits of the active side (k=1 gives 100..0; k=LAMPS gives all ones). Step increments at each step end.
  - At the step end of step LAMPS: go to GAP if HOLD_OFF>0, else IDLE.
- HAZ: L=R=all ones for DIV cycles, then GAP (or IDLE if HOLD_OFF=0).
- GAP: turn lamps off for HOLD_OFF*DIV cycles, then IDLE.
  - left, right and hazard are ignored in GAP and are not latched. A held request restarts on the first clock in IDLE, giving a repeat period of (LAMPS+HOLD_OFF)*DIV + 1 cycles.
- Preemption:
  - hazard=1 during LEFT or RIGHT: the next edge enters HAZ, tick=0, step=0.
  - left/right changes during an active sequence are ignored.
  - hazard during HAZ or GAP is ignored.
- Brake overlay (brake sampled at the same edge as the state):
  - LEFT: R=all ones; L follows the sequence.
  - RIGHT: L=all ones; R follows the sequence.
  - IDLE and GAP: L=R=all ones.
  - HAZ: no effect, since both sides are already all ones.
  - busy is unaffected by brake.
- Counter widths:
  - tick: max(1, clog2(DIV)).
  - step: clog2(LAMPS+1).
  - gap: max(1, clog2(HOLD_OFF*DIV)).
  - No counter exceeds its terminal value. Illegal or default state codes go to IDLE with L=R=0.
- DIV=1: each step lasts exactly one clock.

Test Plan:
(LAMPS=3, DIV=2, HOLD_OFF=1 unless noted)
1. Single-cycle left pulse from IDLE -> L=100,100,110,110,111,111,000,000 on successive cycles; R=000 throughout; busy=1 for 8 cycles, then 0.
2. left=right=1 for one cycle -> L=R=111 for 2 cycles, then L=R=000 for 2 cycles (GAP), then IDLE with busy=0.
3. right held high continuously -> R repeats 100,100,110,110,111,111,000,000,000 (the extra 000 is the IDLE cycle); period 9 cycles; L=000.
4. left sequence running, hazard pulsed while L=110 -> next edge L=R=111 for 2 cycles, then 000 for 2 cycles, then IDLE; left sequence does not resume.
5. brake=1 during a right sequence -> L=111 while R steps 100/110/111; in GAP and IDLE L=R=111; brake during HAZ leaves L=R=111; busy unchanged by brake.
6. reset driven low mid-cycle while L=110 -> L=R=000 and busy=0 immediately, without a clock edge; a right pulse during GAP is ignored; LAMPS=5, DIV=1 left pulse -> L=10000,11000,11100,11110,11111,00000.
